// File: rtl/debounce_array.sv
// Multi-channel debouncer: 2-flop synchroniser, per-channel stability counter, press/release pulses
// and a lowest-index key code. Define DEBOUNCE_REPEAT_EN to add per-channel auto-repeat on press.
module debounce_array #(
  parameter int CHANNELS      = 16,
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         noisy,
  output logic [CHANNELS-1:0]         debounced,
  output logic [CHANNELS-1:0]         press,
  output logic [CHANNELS-1:0]         released,
  output logic                        any_pressed,
  output logic [$clog2(CHANNELS)-1:0] key_code
);

  localparam int KW = $clog2(CHANNELS);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  if (CHANNELS < 2 || CHANNELS > 32 || STABLE_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("debounce_array: illegal parameter value");
  end

  // Counter advance, held at the terminal count rather than wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + CW'(1);
  endfunction

  logic [CHANNELS-1:0] meta_p0;
  logic [CHANNELS-1:0] sync_p1;
  logic [CW-1:0]       cnt_p2 [CHANNELS];
  logic [CHANNELS-1:0] flip;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RPT_MAX) + 1;
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rpt [CHANNELS];
`endif

  // A channel flips when its synchronised level has disagreed for the full window.
  always_comb begin
    flip = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      flip[i] = (sync_p1[i] != debounced[i]) && (cnt_p2[i] == CNT_MAX);
    end
    rise = flip & sync_p1;
    fall = flip & ~sync_p1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_p0   <= '0;
      sync_p1   <= '0;
      debounced <= '0;
      press     <= '0;
      released  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_p2[i] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
        rpt[i]    <= '0;
`endif
      end
    end else begin
      // stage p0/p1: synchroniser
      meta_p0 <= noisy;
      sync_p1 <= meta_p0;
      // stage p2: stability count, level update and edge pulses
      debounced <= debounced ^ flip;
      press     <= rise;
      released  <= fall;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_p1[i] == debounced[i] || flip[i])
          cnt_p2[i] <= '0;
        else
          cnt_p2[i] <= sat_inc(cnt_p2[i]);
`ifdef DEBOUNCE_REPEAT_EN
        // Down-counter armed at the press; a repeat that lands on a release is dropped.
        if (rise[i]) begin
          rpt[i] <= RPT_FIRST;
        end else if (!debounced[i] || fall[i]) begin
          rpt[i] <= '0;
        end else if (rpt[i] == '0) begin
          press[i] <= 1'b1;
          rpt[i]   <= RPT_NEXT;
        end else begin
          rpt[i] <= rpt[i] - RW'(1);
        end
`endif
      end
    end
  end

  // Lowest-numbered active channel wins; scanning downward leaves it as the last assignment.
  always_comb begin
    key_code = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (debounced[i]) key_code = KW'(i);
    end
  end

  assign any_pressed = |debounced;

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array (16 channels, 4-cycle window): vector table, directed corner sequences
// and random toggling checked every cycle against a sample-history reference model.
module tb_debounce_array;
  localparam int CH = 16;
  localparam int S  = 4;
  localparam int D  = 10;
  localparam int P  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] noisy;
  logic [15:0] debounced;
  logic [15:0] press;
  logic [15:0] released;
  logic        any_pressed;
  logic [3:0]  key_code;

  int vectors = 0;
  int miscompares = 0;

  debounce_array #(
    .CHANNELS(CH), .STABLE_CYCLES(S), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk), .reset(reset), .noisy(noisy), .debounced(debounced), .press(press),
    .released(released), .any_pressed(any_pressed), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples per edge, synchronised samples, last flip / press edge per channel.
  logic [15:0] m_deb, m_press, m_rel;
  logic [15:0] nq[$];
  logic [15:0] sq[$];
  int          k;
  int          last_flip [CH];
  int          t0 [CH];

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_deb = '0; m_press = '0; m_rel = '0;
    nq.delete(); sq.delete();
    k = 0;
    for (int c = 0; c < CH; c++) begin last_flip[c] = 0; t0[c] = 0; end
  endtask

  task automatic model_step();
    logic [15:0] sync_pre, old;
    bit all_diff;
    k++;
    sync_pre = (nq.size() >= 2) ? nq[nq.size()-2] : 16'h0;
    nq.push_back(noisy);
    if (nq.size() > 4) void'(nq.pop_front());
    sq.push_back(sync_pre);
    if (sq.size() > S) void'(sq.pop_front());
    old = m_deb; m_press = '0; m_rel = '0;
    for (int c = 0; c < CH; c++) begin
      all_diff = (sq.size() == S) && (k - last_flip[c] >= S);
      for (int j = 0; j < sq.size(); j++) if (sq[j][c] == old[c]) all_diff = 0;
      if (all_diff) begin
        m_deb[c] = ~old[c];
        last_flip[c] = k;
        if (m_deb[c]) begin m_press[c] = 1'b1; t0[c] = k; end
        else m_rel[c] = 1'b1;
      end
`ifdef DEBOUNCE_REPEAT_EN
      else if (old[c] && (k - t0[c]) >= D && ((k - t0[c] - D) % P) == 0) m_press[c] = 1'b1;
`endif
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    chk("debounced", debounced, m_deb);
    chk("press", press, m_press);
    chk("release", released, m_rel);
    chk("any_pressed", any_pressed, |m_deb);
    chk("key_code", key_code, lowest(m_deb));
  endtask

  // Assert reset mid-cycle, check outputs clear without a clock edge, release mid-cycle.
  task automatic pulse_reset(input int cycles);
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("reset_debounced", debounced, 32'h0);
    chk("reset_press", press, 32'h0);
    chk("reset_release", released, 32'h0);
    chk("reset_any", any_pressed, 32'h0);
    chk("reset_key", key_code, 32'h0);
    repeat (cycles) tick();
    #3 reset = 1'b0;
  endtask

  task automatic settle();
    noisy = '0;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [15:0] noisy;
    int          hold;
    logic [15:0] deb;
    logic [3:0]  key;
    logic        any;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pc;
    int pq[$];
    int rq[$];
    int exp_q[$];
    logic [15:0] m;

    tbl[0] = '{16'h0020, 6, 16'h0020, 4'd5, 1'b1};
    tbl[1] = '{16'h0024, 6, 16'h0024, 4'd2, 1'b1};
    tbl[2] = '{16'h0020, 6, 16'h0020, 4'd5, 1'b1};
    tbl[3] = '{16'h8021, 6, 16'h8021, 4'd0, 1'b1};
    tbl[4] = '{16'h8020, 5, 16'h8021, 4'd0, 1'b1};
    tbl[5] = '{16'h8020, 1, 16'h8020, 4'd5, 1'b1};
    tbl[6] = '{16'h0000, 6, 16'h0000, 4'd0, 1'b0};

    reset = 1'b1;
    noisy = '0;
    model_reset();
    repeat (2) tick();
    #3 reset = 1'b0;

    for (int t = 0; t < 7; t++) begin
      noisy = tbl[t].noisy;
      repeat (tbl[t].hold) tick();
      chk("tbl_debounced", debounced, tbl[t].deb);
      chk("tbl_key_code", key_code, tbl[t].key);
      chk("tbl_any", any_pressed, tbl[t].any);
    end

    // Clean step on channel 5.
    settle();
    noisy = 16'h0020;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("step_early", debounced, 32'h0);
      if (e == 6) begin
        chk("step_deb", debounced, 32'h0020);
        chk("step_press", press, 32'h0020);
        chk("step_any", any_pressed, 32'h1);
        chk("step_key", key_code, 32'd5);
      end
      if (e == 7) chk("step_press_gone", press, 32'h0);
    end

    // Bouncing channel 3: only the final sustained rise counts.
    settle();
    pc = 0;
    for (int b = 0; b < 4; b++) begin
      noisy[3] = (b % 2 == 0);
      tick();
      if (press[3]) pc++;
    end
    noisy[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (press[3]) pc++;
      if (e == 5) chk("bounce_early", debounced[3], 32'h0);
      if (e == 6) chk("bounce_deb", debounced[3], 32'h1);
    end
    chk("bounce_press_count", pc, 32'd1);

    // Release of channel 2 out of 0x0024.
    settle();
    noisy = 16'h0024;
    repeat (8) tick();
    chk("rel_setup_key", key_code, 32'd2);
    noisy = 16'h0020;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        chk("rel_pulse", released, 32'h0004);
        chk("rel_key", key_code, 32'd5);
        chk("rel_deb", debounced, 32'h0020);
      end
      if (e == 7) chk("rel_pulse_gone", released, 32'h0);
    end

    // Simultaneous rises on channels 0 and 15.
    settle();
    noisy = 16'h8001;
    repeat (6) tick();
    chk("simul_press", press, 32'h8001);
    chk("simul_key", key_code, 32'd0);

    // Hold channel 7, then let go; a repeat due on the release edge must not appear.
    settle();
    noisy = 16'h0080;
    for (int e = 1; e <= 34; e++) begin
      if (e == 20) noisy = 16'h0000;
      tick();
      if (press[7]) pq.push_back(e);
      if (released[7]) rq.push_back(e);
    end
    exp_q.push_back(6);
`ifdef DEBOUNCE_REPEAT_EN
    exp_q.push_back(16); exp_q.push_back(19); exp_q.push_back(22);
`endif
    chk("repeat_count", pq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pq.size(); i++) chk("repeat_edge", pq[i], exp_q[i]);
    chk("repeat_rel_count", rq.size(), 32'd1);
    if (rq.size() > 0) chk("repeat_rel_edge", rq[0], 32'd25);

    // All channels high through an asynchronous reset.
    noisy = 16'hFFFF;
    repeat (8) tick();
    chk("pre_reset_deb", debounced, 32'hFFFF);
    pulse_reset(2);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("post_reset_early", debounced, 32'h0);
      if (e == 6) begin
        chk("post_reset_deb", debounced, 32'hFFFF);
        chk("post_reset_press", press, 32'hFFFF);
      end
      if (e == 7) chk("post_reset_press_gone", press, 32'h0);
    end

    // Random bouncing on all channels.
    settle();
    for (int n = 0; n < 600; n++) begin
      m = '0;
      for (int b = 0; b < CH; b++) if ($urandom_range(7) == 0) m[b] = 1'b1;
      noisy = noisy ^ m;
      tick();
      if (n == 300) pulse_reset(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
